// File: rtl/store_buffer_if.sv
// Store buffer port bundle.
//   MEM side   : in_valid, in_rob_id, in_addr, in_data, in_size -> full, empty
//   ROB side   : commit_valid, commit_rob_id, flush
//   Load side  : ld_valid, ld_addr, ld_size -> fwd_hit, fwd_data, fwd_stall
//   D-cache    : dc_req, dc_addr, dc_data, dc_mask <- dc_ack
//   Debug      : drain_state (drain FSM state, 0 = IDLE, 1 = REQ)
// Drain handshake: dc_req rises with dc_addr/dc_data/dc_mask valid and all
// four stay stable until dc_ack is sampled high at a rising edge; that edge
// retires the request. dc_ack while dc_req is low is ignored.
interface store_buffer_if #(
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = 4
);
  logic                       in_valid;
  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id;
  logic [WORD_SIZE-1:0]       in_addr;
  logic [WORD_SIZE-1:0]       in_data;
  logic [1:0]                 in_size;
  logic                       full;
  logic                       empty;
  logic                       commit_valid;
  logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id;
  logic                       flush;
  logic                       ld_valid;
  logic [WORD_SIZE-1:0]       ld_addr;
  logic [1:0]                 ld_size;
  logic                       fwd_hit;
  logic [WORD_SIZE-1:0]       fwd_data;
  logic                       fwd_stall;
  logic                       dc_req;
  logic [WORD_SIZE-1:0]       dc_addr;
  logic [WORD_SIZE-1:0]       dc_data;
  logic [3:0]                 dc_mask;
  logic                       dc_ack;
  logic [0:0]                 drain_state;

  modport slave (
    input  in_valid, in_rob_id, in_addr, in_data, in_size,
    input  commit_valid, commit_rob_id, flush,
    input  ld_valid, ld_addr, ld_size, dc_ack,
    output full, empty, fwd_hit, fwd_data, fwd_stall,
    output dc_req, dc_addr, dc_data, dc_mask, drain_state
  );

  modport master (
    output in_valid, in_rob_id, in_addr, in_data, in_size,
    output commit_valid, commit_rob_id, flush,
    output ld_valid, ld_addr, ld_size, dc_ack,
    input  full, empty, fwd_hit, fwd_data, fwd_stall,
    input  dc_req, dc_addr, dc_data, dc_mask, drain_state
  );
endinterface

// File: rtl/store_buffer.sv
// In-order circular buffer of executed-but-uncommitted stores between the MEM
// stage and the D-cache. Stores are allocated at tail, committed in program
// order by the ROB, drained oldest-first to the D-cache and searched
// (youngest first) by loads for store-to-load forwarding.
// Ports: clk, rst (synchronous, active-high) and the store_buffer_if slave
// modport carrying the MEM, ROB, load-lookup and D-cache signals.
module store_buffer #(
  parameter int N               = 4,
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(N);
  localparam int CW = PW + 1;
  localparam int AW = WORD_SIZE - 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [N-1:0]               valid_q, cmt_q;
  logic [ROB_ENTRY_WIDTH-1:0] rob_q  [N];
  logic [AW-1:0]              waddr_q[N];
  logic [3:0]                 mask_q [N];
  logic [WORD_SIZE-1:0]       data_q [N];
  logic [PW-1:0]              head_q, tail_q;
  logic [CW-1:0]              count_q;
  logic [0:0]                 state_q;

  function automatic logic [3:0] size_mask(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  logic alloc, drain, cmt_found, commit_hit;
  logic [PW-1:0] c_idx, cmt_idx, f_idx;
  logic [N-1:0]  cmt_next, drain_clr, alloc_set;
  logic [CW-1:0] kept_cnt;
  logic [3:0]    ld_mask;

  assign sb.full        = (count_q == CW'(N));
  assign sb.empty       = (count_q == '0);
  assign sb.dc_req      = (state_q == ST_REQ);
  assign sb.dc_addr     = {waddr_q[head_q], 2'b00};
  assign sb.dc_data     = data_q[head_q];
  assign sb.dc_mask     = mask_q[head_q];
  assign sb.drain_state = state_q;

  // full comes from the registered count: a drain in the same cycle does not
  // make room for the incoming store.
  assign alloc = sb.in_valid && !sb.full && !sb.flush;
  assign drain = (state_q == ST_REQ) && sb.dc_ack;

  // Commits arrive in program order, so only the oldest uncommitted entry can
  // match. An entry allocated this cycle is not yet valid and cannot match.
  always_comb begin
    cmt_found = 1'b0;
    cmt_idx   = head_q;
    c_idx     = head_q;
    for (int i = 0; i < N; i++) begin
      c_idx = head_q + PW'(i);
      if (!cmt_found && CW'(i) < count_q && valid_q[c_idx] && !cmt_q[c_idx]) begin
        cmt_found = 1'b1;
        cmt_idx   = c_idx;
      end
    end
  end

  assign commit_hit = sb.commit_valid && cmt_found && (rob_q[cmt_idx] == sb.commit_rob_id);

  // Commit is folded in before flush so a same-cycle committed store survives.
  // Committed entries always form a prefix starting at head, so their count
  // locates the post-flush tail.
  always_comb begin
    cmt_next  = cmt_q;
    drain_clr = '0;
    alloc_set = '0;
    kept_cnt  = '0;
    if (commit_hit) cmt_next[cmt_idx] = 1'b1;
    if (drain)      drain_clr[head_q] = 1'b1;
    if (alloc)      alloc_set[tail_q] = 1'b1;
    for (int i = 0; i < N; i++)
      kept_cnt = kept_cnt + CW'(valid_q[i] & cmt_next[i]);
  end

  // Oldest-to-youngest walk; a later overlapping entry overrides an earlier
  // one, so the youngest overlapping store decides hit versus stall.
  always_comb begin
    ld_mask      = size_mask(sb.ld_addr[1:0], sb.ld_size);
    sb.fwd_hit   = 1'b0;
    sb.fwd_stall = 1'b0;
    sb.fwd_data  = '0;
    f_idx        = head_q;
    for (int i = 0; i < N; i++) begin
      f_idx = head_q + PW'(i);
      if (sb.ld_valid && CW'(i) < count_q && valid_q[f_idx] &&
          waddr_q[f_idx] == sb.ld_addr[WORD_SIZE-1:2] && |(mask_q[f_idx] & ld_mask)) begin
        sb.fwd_hit   = ((mask_q[f_idx] & ld_mask) == ld_mask);
        sb.fwd_stall = ((mask_q[f_idx] & ld_mask) != ld_mask);
        sb.fwd_data  = data_q[f_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cmt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ST_IDLE;
    end else begin
      if (state_q == ST_IDLE) begin
        if (valid_q[head_q] && cmt_q[head_q]) state_q <= ST_REQ;
      end else if (sb.dc_ack) begin
        state_q <= ST_IDLE;
      end
      if (drain) head_q <= head_q + PW'(1);
      if (sb.flush) begin
        tail_q  <= head_q + kept_cnt[PW-1:0];
        count_q <= kept_cnt - CW'(drain);
        valid_q <= valid_q & cmt_next & ~drain_clr;
        cmt_q   <= valid_q & cmt_next & ~drain_clr;
      end else begin
        if (alloc) tail_q <= tail_q + PW'(1);
        count_q <= count_q + CW'(alloc) - CW'(drain);
        valid_q <= (valid_q & ~drain_clr) | alloc_set;
        cmt_q   <= cmt_next & ~drain_clr & ~alloc_set;
      end
    end
  end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (alloc) begin
      rob_q[tail_q]   <= sb.in_rob_id;
      waddr_q[tail_q] <= sb.in_addr[WORD_SIZE-1:2];
      mask_q[tail_q]  <= size_mask(sb.in_addr[1:0], sb.in_size);
      data_q[tail_q]  <= sb.in_data << {sb.in_addr[1:0], 3'b000};
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int N  = 4;
  localparam int WS = 32;
  localparam int RW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_if #(.WORD_SIZE(WS), .ROB_ENTRY_WIDTH(RW)) sb();
  store_buffer #(.N(N), .WORD_SIZE(WS), .ROB_ENTRY_WIDTH(RW)) dut (
    .clk(clk),
    .rst(rst),
    .sb (sb)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [RW-1:0] rob;
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [1:0]    size;
    bit            cmt;
  } st_t;

  st_t         mq[$];      // buffered stores, oldest first
  logic [67:0] exp_q[$];   // expected drain beats {addr, mask, data}
  bit          m_busy;     // a drain request is expected to be outstanding
  int          total_cnt, pass_cnt, fail_cnt;
  int          n_drain;
  logic [RW-1:0] rob_ctr;

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_mask(input st_t s);
    logic [3:0] m;
    int off;
    m = '0;
    off = int'(s.addr % 4);
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + nbytes(s.size)) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] lane(input st_t s);
    logic [31:0] d;
    d = s.data << (8 * (s.addr % 4));
    return d;
  endfunction

  function automatic logic [67:0] beat_of(input st_t s);
    return {s.addr & ~32'h3, m_mask(s), lane(s)};
  endfunction

  function automatic int first_uncommitted();
    for (int k = 0; k < mq.size(); k++)
      if (!mq[k].cmt) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic [67:0] b;
    logic [31:0] ls, le, ss, se, e_data;
    bit e_hit, e_stall, found;
    if (rst) return;
    chk("full", sb.full, 32'(mq.size() == N));
    chk("empty", sb.empty, 32'(mq.size() == 0));
    chk("dc_req", sb.dc_req, 32'(m_busy));
    if (m_busy && exp_q.size() > 0) begin
      b = exp_q[0];
      chk("dc_addr", sb.dc_addr, b[67:36]);
      chk("dc_mask", sb.dc_mask, 32'(b[35:32]));
      chk("dc_data", sb.dc_data, b[31:0]);
    end
    e_hit = 0; e_stall = 0; e_data = '0; found = 0;
    ls = sb.ld_addr;
    le = ls + nbytes(sb.ld_size);
    for (int j = mq.size() - 1; j >= 0; j--) begin
      ss = mq[j].addr;
      se = ss + nbytes(mq[j].size);
      if (!found && ss < le && ls < se) begin
        found   = 1;
        e_hit   = (ss <= ls) && (le <= se);
        e_stall = !e_hit;
        e_data  = lane(mq[j]);
      end
    end
    if (sb.ld_valid) begin
      chk("fwd_hit", sb.fwd_hit, 32'(e_hit));
      chk("fwd_stall", sb.fwd_stall, 32'(e_stall));
      if (e_hit) chk("fwd_data", sb.fwd_data, e_data);
    end else begin
      chk("fwd_hit_idle", sb.fwd_hit, 0);
      chk("fwd_stall_idle", sb.fwd_stall, 0);
    end
  endtask

  task automatic model_update();
    int pre_size, j;
    bit front_cmt, do_drain;
    st_t s;
    st_t keep[$];
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_busy = 0;
      return;
    end
    pre_size  = mq.size();
    front_cmt = (pre_size > 0) && mq[0].cmt;
    do_drain  = m_busy && sb.dc_ack;
    if (sb.commit_valid) begin
      j = first_uncommitted();
      if (j >= 0 && mq[j].rob == sb.commit_rob_id) begin
        mq[j].cmt = 1;
        exp_q.push_back(beat_of(mq[j]));
      end
    end
    if (sb.flush) begin
      foreach (mq[k]) if (mq[k].cmt) keep.push_back(mq[k]);
      mq = keep;
    end
    if (do_drain) begin
      void'(mq.pop_front());
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_busy = 0;
    end else if (!m_busy && front_cmt) begin
      m_busy = 1;
    end
    if (sb.in_valid && pre_size < N && !sb.flush) begin
      s.rob = sb.in_rob_id; s.addr = sb.in_addr; s.data = sb.in_data;
      s.size = sb.in_size; s.cmt = 0;
      mq.push_back(s);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    sb.in_valid = 0; sb.in_rob_id = '0; sb.in_addr = '0; sb.in_data = '0; sb.in_size = 2'b10;
    sb.commit_valid = 0; sb.commit_rob_id = '0; sb.flush = 0;
    sb.ld_valid = 0; sb.ld_addr = '0; sb.ld_size = 2'b10; sb.dc_ack = 0;
  endtask

  task automatic put(input logic [RW-1:0] rob, input logic [31:0] addr,
                     input logic [31:0] data, input logic [1:0] size);
    sb.in_valid = 1; sb.in_rob_id = rob; sb.in_addr = addr; sb.in_data = data; sb.in_size = size;
    cycle();
    sb.in_valid = 0;
  endtask

  task automatic do_flush();
    sb.flush = 1;
    cycle();
    sb.flush = 0;
  endtask

  task automatic rand_addr(input logic [1:0] size, output logic [31:0] addr);
    logic [31:0] off;
    off = (size == 2'b10) ? 0 : (size == 2'b01) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
    addr = 32'h40 + 4 * $urandom_range(0, 1) + off;
  endtask

  task automatic rand_inputs();
    logic [1:0] sz;
    logic [31:0] a;
    int j;
    sz = 2'($urandom_range(0, 2));
    rand_addr(sz, a);
    sb.in_valid = ($urandom_range(0, 99) < 60);
    sb.in_size = sz; sb.in_addr = a;
    sb.in_data = $urandom & ((sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF);
    sb.in_rob_id = rob_ctr;
    if (sb.in_valid) rob_ctr = rob_ctr + 1'b1;
    sb.commit_valid = ($urandom_range(0, 99) < 50);
    j = first_uncommitted();
    if (j >= 0 && $urandom_range(0, 99) < 80) sb.commit_rob_id = mq[j].rob;
    else sb.commit_rob_id = RW'($urandom);
    sb.flush  = ($urandom_range(0, 99) < 4);
    sb.dc_ack = ($urandom_range(0, 99) < 50);
    sz = 2'($urandom_range(0, 2));
    rand_addr(sz, a);
    sb.ld_valid = ($urandom_range(0, 99) < 70);
    sb.ld_size = sz; sb.ld_addr = a;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    total_cnt = 0; pass_cnt = 0; fail_cnt = 0; m_busy = 0; rob_ctr = '0;
    rst = 1;
    idle_inputs();
    cycle();
    cycle();
    rst = 0;
    chk("rst_full", sb.full, 0);
    chk("rst_empty", sb.empty, 1);
    chk("rst_dc_req", sb.dc_req, 0);
    chk("rst_fwd_hit", sb.fwd_hit, 0);
    chk("rst_fwd_stall", sb.fwd_stall, 0);

    // single word store, commit, drain with latency t+2
    put(4'd3, 32'h100, 32'hDEAD_BEEF, 2'b10);
    sb.commit_valid = 1; sb.commit_rob_id = 4'd3;
    cycle();
    sb.commit_valid = 0;
    chk("lat_req_t1", sb.dc_req, 0);
    cycle();
    chk("lat_req_t2", sb.dc_req, 1);
    chk("lat_addr", sb.dc_addr, 32'h100);
    chk("lat_mask", sb.dc_mask, 32'hF);
    chk("lat_data", sb.dc_data, 32'hDEAD_BEEF);
    sb.dc_ack = 1;
    cycle();
    sb.dc_ack = 0;
    chk("lat_empty", sb.empty, 1);
    chk("lat_req_done", sb.dc_req, 0);

    // fill, overflow attempt, in-order drains
    for (int k = 0; k < 4; k++) put(RW'(4 + k), 32'h10 + 4 * k, 32'h1000 + k, 2'b10);
    chk("fill_full", sb.full, 1);
    put(4'd8, 32'h50, 32'h5555, 2'b10);
    chk("overflow_full", sb.full, 1);
    sb.dc_ack = 1;
    n_drain = 0;
    for (int c = 0; c < 24; c++) begin
      sb.commit_valid = (c < 4);
      sb.commit_rob_id = RW'(4 + c);
      if (sb.dc_req) n_drain++;
      cycle();
    end
    sb.commit_valid = 0; sb.dc_ack = 0;
    chk("fill_drains", n_drain, 4);
    chk("fill_empty", sb.empty, 1);

    // partial overlap stalls, exact byte hits
    put(4'd9, 32'h203, 32'hAB, 2'b00);
    sb.ld_valid = 1; sb.ld_addr = 32'h200; sb.ld_size = 2'b10;
    #1;
    chk("byte_stall", sb.fwd_stall, 1);
    chk("byte_stall_hit", sb.fwd_hit, 0);
    sb.ld_addr = 32'h203; sb.ld_size = 2'b00;
    #1;
    chk("byte_hit", sb.fwd_hit, 1);
    chk("byte_data", sb.fwd_data, 32'hAB00_0000);
    sb.ld_valid = 0;
    do_flush();
    chk("byte_flush_empty", sb.empty, 1);

    // youngest store wins
    put(4'd10, 32'h300, 32'h1111_1111, 2'b10);
    put(4'd11, 32'h300, 32'h2222_2222, 2'b10);
    sb.ld_valid = 1; sb.ld_addr = 32'h300; sb.ld_size = 2'b10;
    #1;
    chk("young_hit", sb.fwd_hit, 1);
    chk("young_data", sb.fwd_data, 32'h2222_2222);
    sb.ld_valid = 0;
    do_flush();
    chk("young_flush_empty", sb.empty, 1);

    // flush keeps the committed oldest entry only
    put(4'd12, 32'h400, 32'hA, 2'b10);
    put(4'd13, 32'h404, 32'hB, 2'b10);
    put(4'd14, 32'h408, 32'hC, 2'b10);
    sb.commit_valid = 1; sb.commit_rob_id = 4'd12;
    cycle();
    sb.commit_valid = 0;
    do_flush();
    chk("flush_not_empty", sb.empty, 0);
    sb.ld_valid = 1; sb.ld_addr = 32'h404; sb.ld_size = 2'b10;
    #1;
    chk("flush_dropped", sb.fwd_hit, 0);
    sb.ld_valid = 0;
    sb.dc_ack = 1;
    n_drain = 0;
    for (int c = 0; c < 10; c++) begin
      if (sb.dc_req) begin
        n_drain++;
        chk("flush_drain_addr", sb.dc_addr, 32'h400);
      end
      cycle();
    end
    sb.dc_ack = 0;
    chk("flush_drains", n_drain, 1);
    chk("flush_final_empty", sb.empty, 1);

    // wrong rob id is ignored
    put(4'd15, 32'h500, 32'h55, 2'b10);
    sb.commit_valid = 1; sb.commit_rob_id = 4'd0;
    cycle();
    sb.commit_valid = 0;
    for (int c = 0; c < 3; c++) begin
      chk("wrong_rob_req", sb.dc_req, 0);
      cycle();
    end
    chk("wrong_rob_kept", sb.empty, 0);
    do_flush();
    chk("wrong_rob_flush", sb.empty, 1);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      cycle();
    end
    idle_inputs();
    cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order circular buffer of executed-but-uncommitted stores, sitting between the MEM stage and the D-cache.
- The MEM stage allocates an entry when a store resolves its address and data.
- The ROB grants permission when that store reaches head (sb_store_permission / sb_rob_id).
- Committed entries drain oldest-first to the D-cache through a req/ack handshake.
- Younger loads search the buffer for store-to-load forwarding.

Parameters:
- N, 4, number of entries (power of 2).
- WORD_SIZE, 32, data/address width.
- ROB_ENTRY_WIDTH, 4, width of a ROB id.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  MEM stage presents a store
- in_rob_id  in  ROB_ENTRY_WIDTH  ROB id of the store
- in_addr  in  WORD_SIZE  byte address
- in_data  in  WORD_SIZE  store data, right-aligned
- in_size  in  2  00 byte, 01 half, 10 word
- full  out  1  no free entry
- empty  out  1  no valid entry
- commit_valid  in  1  ROB store permission
- commit_rob_id  in  ROB_ENTRY_WIDTH  ROB id being committed
- flush  in  1  exception; discard uncommitted entries
- ld_valid  in  1  load lookup
- ld_addr  in  WORD_SIZE  load byte address
- ld_size  in  2  load size, same encoding as in_size
- fwd_hit  out  1  youngest overlapping store fully covers the load
- fwd_data  out  WORD_SIZE  that entry's word-lane data
- fwd_stall  out  1  overlap but not fully covered; load must retry
- dc_req  out  1  drain request
- dc_addr  out  WORD_SIZE  word-aligned address
- dc_data  out  WORD_SIZE  lane-aligned data
- dc_mask  out  4  byte enables
- dc_ack  in  1  D-cache accepted request

Behaviour:
- Reset: rst is synchronous, active-high. It clears head, tail, count, all valid/committed bits and the drain FSM.
  - Outputs after reset: full=0, empty=1, dc_req=0, fwd_hit=0, fwd_stall=0.
  - rst overrides every concurrent event, including an in-flight drain; the D-cache must tolerate a dropped request.
- Entry fields: valid, committed, rob_id, word address (addr[31:2]), mask[3:0], lane data.
  - mask: byte = 1<<addr[1:0]; half = 3<<{addr[1],0}; word = 4'hF.
  - Lane data is in_data shifted left by 8*addr[1:0].
  - Misaligned stores never arrive; MEM raises the exception for them.
- Allocate: at posedge with in_valid && !full && !flush. Write at tail, tail=(tail+1)%N, count++.
  - full is derived from the registered count, so a same-cycle drain does not free space for the incoming store.
- Commit: commit_valid compares commit_rob_id against the oldest valid, uncommitted entry.
  - On match, that entry's committed bit is set.
  - No match, or a match only against an entry being allocated this cycle: ignored.
  - Stores commit in program order, so no CAM over all entries is needed.
- Drain FSM, IDLE/REQ:
  - IDLE: if head is valid && committed, go to REQ.
  - REQ: dc_req=1 and dc_addr/dc_data/dc_mask driven from the head entry, held stable until dc_ack.
  - On ack at posedge: free head, head=(head+1)%N, count--, return to IDLE.
  - Minimum one idle cycle between requests.
  - Latency: a commit at cycle t gives dc_req at t+2.
- Flush: at posedge, every valid uncommitted entry is invalidated, tail is reset to just past the youngest committed entry, and count is adjusted.
  - Committed entries and an in-flight REQ continue draining.
  - A concurrent commit is applied before the flush, so that entry survives.
  - A concurrent in_valid is dropped.
- Forwarding (combinational, no state change):
  - The search runs over valid entries, youngest to oldest, comparing word address and checking mask overlap with the load mask.
  - First overlapping entry whose mask covers the load mask: fwd_hit=1, fwd_data = entry lane data.
  - Overlap without cover: fwd_stall=1.
  - No overlap, or ld_valid=0: both outputs 0. fwd_data is don't-care when fwd_hit=0.
- Simultaneous allocate + drain + commit in one cycle: all three are applied and count is updated by net delta.
- Wrap-around: head and tail index modulo N; count has $clog2(N)+1 bits to distinguish full from empty.

Test Plan:
- Reset, then store word 0xDEADBEEF to 0x100 with rob 3; commit rob 3 at t -> dc_req at t+2 with dc_addr=0x100, dc_mask=F; dc_ack frees entry and empty=1.
- Fill 4 stores with no commits -> full=1; a 5th in_valid is ignored; commit rob ids in order with dc_ack held 1 -> 4 drains in order and empty=1.
- Store byte 0xAB to 0x203 -> load word 0x200 gives fwd_stall=1; load byte 0x203 gives fwd_hit=1, fwd_data=0xAB000000.
- Two stores to 0x300, 0x11111111 then 0x22222222 -> load word 0x300 forwards 0x22222222 (youngest wins).
- 3 entries with the oldest committed, then flush -> 2 entries dropped; the committed entry still drains; count ends at 0.
- Commit with wrong rob id -> no state change; dc_req stays 0.
